// File: rtl/mouse_pkg.sv
// rtl/mouse_pkg.sv - shared constants and FSM encoding for the PS/2 mouse tracker
package mouse_pkg;

  // Default screen geometry and power-on cursor position
  localparam int H_MAX_DEF  = 640;
  localparam int V_MAX_DEF  = 480;
  localparam int INIT_X_DEF = 320;
  localparam int INIT_Y_DEF = 240;

  // Cursor coordinate width, PS/2 movement delta width, signed arithmetic width
  localparam int POS_W   = 10;
  localparam int DELTA_W = 9;
  localparam int CALC_W  = 12;

  // Which byte of the 3-byte PS/2 movement packet is expected next
  typedef enum logic [1:0] {
    WAIT_B0 = 2'd0,
    WAIT_B1 = 2'd1,
    WAIT_B2 = 2'd2
  } state_t;

endpackage

// File: rtl/mouse_axis_clamp.sv
// rtl/mouse_axis_clamp.sv - adds a signed delta to one cursor axis and saturates to 0..max-1
module mouse_axis_clamp
  import mouse_pkg::*;
(
  input  logic        [POS_W-1:0]   i_pos,
  input  logic signed [DELTA_W:0]   i_delta,
  input  logic        [POS_W-1:0]   i_max,
  output logic        [POS_W-1:0]   o_pos
);

  logic signed [CALC_W-1:0] w_sum;
  logic signed [CALC_W-1:0] w_lim;

  // Delta carries one extra bit so that a negated -256 (Y axis) still fits
  assign w_sum = $signed({{(CALC_W-POS_W){1'b0}}, i_pos})
               + $signed({{(CALC_W-DELTA_W-1){i_delta[DELTA_W]}}, i_delta});
  assign w_lim = $signed({{(CALC_W-POS_W){1'b0}}, i_max}) - $signed(CALC_W'(1));

  // Saturate instead of wrapping so the cursor sticks at the screen edges
  always_comb begin
    o_pos = w_sum[POS_W-1:0];
    if (w_sum < 0) begin
      o_pos = '0;
    end else if (w_sum > w_lim) begin
      o_pos = w_lim[POS_W-1:0];
    end
  end

endmodule

// File: rtl/mouse_tracker.sv
// rtl/mouse_tracker.sv - assembles PS/2 mouse packets into a clamped absolute cursor position
module mouse_tracker
  import mouse_pkg::*;
#(
  parameter int H_MAX   = H_MAX_DEF,
  parameter int V_MAX   = V_MAX_DEF,
  parameter int INIT_X  = INIT_X_DEF,
  parameter int INIT_Y  = INIT_Y_DEF,
  parameter int TIMEOUT = 1_000_000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [7:0]       rx_data,
  input  logic             rx_done,
  output logic [POS_W-1:0] mouse_x,
  output logic [POS_W-1:0] mouse_y,
  output logic [2:0]       btn,
  output logic             pkt_valid,
  output logic             sync_err
);

  localparam int IDLE_W = $clog2(TIMEOUT + 1);

  state_t              r_state;
  state_t              w_state_nxt;
  logic [7:0]          r_b0;
  logic [7:0]          r_b1;
  logic [IDLE_W-1:0]   r_idle;
  logic [POS_W-1:0]    r_mouse_x;
  logic [POS_W-1:0]    r_mouse_y;
  logic [2:0]          r_btn;
  logic                r_pkt_valid;
  logic                r_sync_err;

  logic                w_latch_b0;
  logic                w_latch_b1;
  logic                w_commit;
  logic                w_reject;
  logic                w_idle_hit;
  logic [DELTA_W-1:0]  w_dx;
  logic [DELTA_W-1:0]  w_dy;
  logic [DELTA_W:0]    w_dx_ext;
  logic [DELTA_W:0]    w_dy_neg;
  logic [POS_W-1:0]    w_new_x;
  logic [POS_W-1:0]    w_new_y;
  logic                w_unused;

  // Byte 0 bit 3 is only the always-one sync marker, checked straight off rx_data
  assign w_unused   = r_b0[3];
  assign w_idle_hit = (r_idle == IDLE_W'(TIMEOUT - 1));

  // Byte 2 is consumed directly from rx_data on its strobe; it is never stored
  assign w_dx     = {r_b0[4], r_b1};
  assign w_dy     = {r_b0[5], rx_data};
  assign w_dx_ext = {w_dx[DELTA_W-1], w_dx};
  assign w_dy_neg = -{w_dy[DELTA_W-1], w_dy};

  mouse_axis_clamp u_clamp_x (
    .i_pos   (r_mouse_x),
    .i_delta (w_dx_ext),
    .i_max   (POS_W'(H_MAX)),
    .o_pos   (w_new_x)
  );

  // PS/2 reports up as positive, screen rows grow downward
  mouse_axis_clamp u_clamp_y (
    .i_pos   (r_mouse_y),
    .i_delta (w_dy_neg),
    .i_max   (POS_W'(V_MAX)),
    .o_pos   (w_new_y)
  );

  // Packet state register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= WAIT_B0;
    else        r_state <= w_state_nxt;
  end

  // Next-state and per-cycle strobes; a byte strobe always beats the idle timeout
  always_comb begin
    w_state_nxt = r_state;
    w_latch_b0  = 1'b0;
    w_latch_b1  = 1'b0;
    w_commit    = 1'b0;
    w_reject    = 1'b0;
    case (r_state)
      WAIT_B0: begin
        if (rx_done) begin
          if (rx_data[3]) begin
            w_latch_b0  = 1'b1;
            w_state_nxt = WAIT_B1;
          end else begin
            w_reject = 1'b1;
          end
        end
      end
      WAIT_B1: begin
        if (rx_done) begin
          w_latch_b1  = 1'b1;
          w_state_nxt = WAIT_B2;
        end else if (w_idle_hit) begin
          w_state_nxt = WAIT_B0;
        end
      end
      WAIT_B2: begin
        if (rx_done) begin
          w_commit    = 1'b1;
          w_state_nxt = WAIT_B0;
        end else if (w_idle_hit) begin
          w_state_nxt = WAIT_B0;
        end
      end
      default: w_state_nxt = WAIT_B0;
    endcase
  end

  // Idle counter: counts gaps mid-packet, cleared by any byte or return to WAIT_B0
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                                r_idle <= '0;
    else if (rx_done || w_state_nxt == WAIT_B0) r_idle <= '0;
    else                                       r_idle <= r_idle + IDLE_W'(1);
  end

  // Byte latches for the first two bytes of the packet
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_b0 <= '0;
      r_b1 <= '0;
    end else begin
      if (w_latch_b0) r_b0 <= rx_data;
      if (w_latch_b1) r_b1 <= rx_data;
    end
  end

  // Registered outputs; an overflow flag freezes only its own axis
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_mouse_x   <= POS_W'(INIT_X);
      r_mouse_y   <= POS_W'(INIT_Y);
      r_btn       <= '0;
      r_pkt_valid <= 1'b0;
      r_sync_err  <= 1'b0;
    end else begin
      r_pkt_valid <= w_commit & ~r_pkt_valid;
      r_sync_err  <= w_reject & ~r_sync_err;
      if (w_commit) begin
        r_btn <= r_b0[2:0];
        if (!r_b0[6]) r_mouse_x <= w_new_x;
        if (!r_b0[7]) r_mouse_y <= w_new_y;
      end
    end
  end

  assign mouse_x   = r_mouse_x;
  assign mouse_y   = r_mouse_y;
  assign btn       = r_btn;
  assign pkt_valid = r_pkt_valid;
  assign sync_err  = r_sync_err;

endmodule

// File: tb/tb_mouse_tracker.sv
// tb/tb_mouse_tracker.sv - directed and randomized self-checking bench for mouse_tracker
module tb_mouse_tracker;

  localparam int H  = 640;
  localparam int V  = 480;
  localparam int IX = 320;
  localparam int IY = 240;
  localparam int TO = 12;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [7:0] rx_data = 8'h00;
  logic       rx_done = 1'b0;
  logic [9:0] mouse_x;
  logic [9:0] mouse_y;
  logic [2:0] btn;
  logic       pkt_valid;
  logic       sync_err;

  int checks = 0;
  int errors = 0;

  // Reference model: cursor, buttons, pending bytes, idle cycles since last byte
  int         m_x;
  int         m_y;
  logic [2:0] m_btn;
  logic [7:0] m_q[$];
  int         m_idle;

  always #5 clk = ~clk;

  mouse_tracker #(
    .H_MAX   (H),
    .V_MAX   (V),
    .INIT_X  (IX),
    .INIT_Y  (IY),
    .TIMEOUT (TO)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .rx_data   (rx_data),
    .rx_done   (rx_done),
    .mouse_x   (mouse_x),
    .mouse_y   (mouse_y),
    .btn       (btn),
    .pkt_valid (pkt_valid),
    .sync_err  (sync_err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int clampv(input int v, input int mx);
    if (v < 0) return 0;
    if (v > mx - 1) return mx - 1;
    return v;
  endfunction

  task automatic check_outputs(input string tag);
    chk({tag, "_x"}, 32'(mouse_x), m_x);
    chk({tag, "_y"}, 32'(mouse_y), m_y);
    chk({tag, "_btn"}, 32'(btn), 32'(m_btn));
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset   = 1'b0;
    rx_done = 1'b0;
    repeat (2) @(negedge clk);
    m_x = IX; m_y = IY; m_btn = 3'b000; m_idle = 0;
    m_q.delete();
    check_outputs("reset");
    chk("reset_pkt_valid", 32'(pkt_valid), 0);
    chk("reset_sync_err", 32'(sync_err), 0);
    reset = 1'b1;
  endtask

  // Drive one byte strobe, then leave idle_after idle cycles before the next one
  task automatic send(input logic [7:0] b, input int idle_after);
    logic ep, es, seen;
    int dx, dy;
    @(negedge clk);
    rx_data = b;
    rx_done = 1'b1;
    @(negedge clk);
    rx_done = 1'b0;
    rx_data = 8'($urandom);
    ep = 1'b0;
    es = 1'b0;
    if (m_q.size() > 0 && m_idle >= TO) m_q.delete();
    if (m_q.size() == 0 && !b[3]) begin
      es = 1'b1;
    end else begin
      m_q.push_back(b);
      if (m_q.size() == 3) begin
        dx = int'(m_q[1]) - (m_q[0][4] ? 256 : 0);
        dy = int'(m_q[2]) - (m_q[0][5] ? 256 : 0);
        if (!m_q[0][6]) m_x = clampv(m_x + dx, H);
        if (!m_q[0][7]) m_y = clampv(m_y - dy, V);
        m_btn = m_q[0][2:0];
        ep = 1'b1;
        m_q.delete();
      end
    end
    m_idle = idle_after;
    chk("pkt_valid", 32'(pkt_valid), 32'(ep));
    chk("sync_err", 32'(sync_err), 32'(es));
    check_outputs("pos");
    if (idle_after > 1) begin
      seen = 1'b0;
      repeat (idle_after - 1) begin
        @(negedge clk);
        if (pkt_valid !== 1'b0 || sync_err !== 1'b0) seen = 1'b1;
      end
      chk("pulse_width", 32'(seen), 0);
    end
  endtask

  initial begin
    logic [7:0] rb;
    int gap;
    m_x = IX; m_y = IY; m_btn = 3'b000; m_idle = 0;

    // Held in reset from time zero
    @(negedge clk);
    check_outputs("por");
    chk("por_pkt_valid", 32'(pkt_valid), 0);

    // Basic packet: +10 right, +5 up
    do_reset();
    send(8'h08, 2); send(8'h0A, 2); send(8'h05, 3);
    chk("r36_x", 32'(mouse_x), 330);
    chk("r36_y", 32'(mouse_y), 235);

    // Largest negative deltas, clamp on second packet
    do_reset();
    send(8'h38, 2); send(8'h00, 2); send(8'h00, 3);
    chk("r37a_x", 32'(mouse_x), 64);
    chk("r37a_y", 32'(mouse_y), 479);
    send(8'h38, 2); send(8'h00, 2); send(8'h00, 3);
    chk("r37b_x", 32'(mouse_x), 0);
    chk("r37b_y", 32'(mouse_y), 479);

    // Stray byte rejected, then a packet with left button
    do_reset();
    send(8'h00, 3);
    send(8'h09, 2); send(8'h01, 2); send(8'h01, 3);
    chk("r38_x", 32'(mouse_x), 321);
    chk("r38_btn", 32'(btn), 1);

    // Fragment dropped after exactly TIMEOUT idle cycles
    do_reset();
    send(8'h08, 2); send(8'h05, TO);
    send(8'h08, 2); send(8'h02, 2); send(8'h00, 3);
    chk("r39_x", 32'(mouse_x), 322);
    chk("r39_y", 32'(mouse_y), 240);

    // One cycle short of the timeout: the byte still counts
    do_reset();
    send(8'h08, TO - 1); send(8'h03, TO - 1); send(8'h00, 3);
    chk("edge_x", 32'(mouse_x), 323);

    // X overflow freezes X only
    do_reset();
    send(8'h48, 2); send(8'h7F, 2); send(8'h10, 3);
    chk("r40_x", 32'(mouse_x), 320);
    chk("r40_y", 32'(mouse_y), 224);

    // Reset between byte 1 and byte 2
    do_reset();
    send(8'h08, 2); send(8'h01, 2);
    do_reset();
    send(8'h08, 2); send(8'h01, 2); send(8'h00, 3);
    chk("r41_x", 32'(mouse_x), 321);
    chk("r41_y", 32'(mouse_y), 240);

    // Random byte stream with mixed gaps, including timeout and just-short gaps
    do_reset();
    for (int i = 0; i < 150; i++) begin
      rb = 8'($urandom);
      if ($urandom_range(0, 3) != 0) rb[3] = 1'b1;
      case ($urandom_range(0, 9))
        0:       gap = TO;
        1:       gap = TO - 1;
        default: gap = $urandom_range(1, 4);
      endcase
      send(rb, gap);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
